hazard_fwd_ctrl: RTL and testbench

HAZARD_FWD_CTRL -- requirements
Module: hazard_fwd_ctrl

---
 rtl/hazard_fwd_ctrl.sv | 134 +++++++++++++
 tb/tb_hazard_fwd_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_fwd_ctrl.sv
// Purpose: load-use hazard detection and operand-forwarding select generation for the ID stage.
// Latency: mux_sel_A/B and imm_sel registered (apply the cycle after ID); stall is combinational.
// Backpressure: stall holds ins/PC upstream for exactly one cycle per load-use pair; flush overrides stall.
module hazard_fwd_ctrl #(
    parameter logic [4:0] NOP_OP   = 5'b00000,
    parameter logic [4:0] LOAD_OP  = 5'b10000,
    parameter logic [4:0] STORE_OP = 5'b11111
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [23:0] ins,
    input  logic        flush,
    output logic [1:0]  mux_sel_A,
    output logic [1:0]  mux_sel_B,
    output logic        imm_sel,
    output logic [4:0]  RW_dm,
    output logic        stall
);

    typedef enum logic {RUN = 1'b0, LDSTALL = 1'b1} state_t;

    state_t     state;

    // Decoded ID instruction
    logic [4:0] opcode;
    logic [4:0] dst;
    logic [4:0] src_a;
    logic [4:0] src_b;
    logic       writes;
    logic       uses_a;
    logic       uses_b;
    logic       immf;
    logic       is_load;

    // Issue history: h1 is one slot ahead of ID (EX), h2 is DM, h3 is WB.
    // The load flag is only ever consulted in h1, so older slots do not keep it.
    logic       h1_vld, h2_vld, h3_vld;
    logic [4:0] h1_dst, h2_dst, h3_dst;
    logic       h1_ld;

    logic [1:0] fwd_a;
    logic [1:0] fwd_b;
    logic       load_use;
    logic       unused_low;

    // The low nibble of the instruction word belongs to the immediate, not to this block.
    assign unused_low = ^ins[3:0];

    // A history slot supplies a source only if it writes a real register (r0 is hardwired).
    function automatic logic hit(input logic vld, input logic [4:0] hdst, input logic [4:0] src);
        return vld && (hdst != 5'd0) && (hdst == src);
    endfunction

    // Youngest producer wins; an unused source always reads the bank.
    function automatic logic [1:0] fwd_pick(input logic used, input logic m1,
                                            input logic m2, input logic m3);
        logic [1:0] sel;
        sel = 2'b00;
        if (used) begin
            if (m1)      sel = 2'b01;
            else if (m2) sel = 2'b10;
            else if (m3) sel = 2'b11;
        end
        return sel;
    endfunction

    // Field extraction and opcode class decode for the instruction sitting in ID
    always_comb begin
        opcode  = ins[23:19];
        dst     = ins[18:14];
        src_a   = ins[13:9];
        src_b   = ins[8:4];
        writes  = (opcode != NOP_OP) && (opcode != STORE_OP);
        uses_a  = (opcode != NOP_OP);
        uses_b  = !opcode[4] || (opcode == STORE_OP);
        immf    = opcode[4] && (opcode != STORE_OP);
        is_load = (opcode == LOAD_OP);
    end

    // Forwarding selects and load-use detection against the current history
    always_comb begin
        fwd_a    = fwd_pick(uses_a, hit(h1_vld, h1_dst, src_a), hit(h2_vld, h2_dst, src_a),
                            hit(h3_vld, h3_dst, src_a));
        fwd_b    = fwd_pick(uses_b, hit(h1_vld, h1_dst, src_b), hit(h2_vld, h2_dst, src_b),
                            hit(h3_vld, h3_dst, src_b));
        load_use = (state == RUN) && h1_ld &&
                   ((uses_a && hit(h1_vld, h1_dst, src_a)) ||
                    (uses_b && hit(h1_vld, h1_dst, src_b)));
    end

    assign stall = load_use & ~flush;
    assign RW_dm = h2_vld ? h2_dst : 5'd0;

    // History shift, registered selects and the RUN/LDSTALL state; a kill or a stall inserts a bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            h1_vld    <= 1'b0;
            h1_dst    <= 5'd0;
            h1_ld     <= 1'b0;
            h2_vld    <= 1'b0;
            h2_dst    <= 5'd0;
            h3_vld    <= 1'b0;
            h3_dst    <= 5'd0;
            mux_sel_A <= 2'b00;
            mux_sel_B <= 2'b00;
            imm_sel   <= 1'b0;
        end else begin
            h3_vld <= h2_vld;
            h3_dst <= h2_dst;
            h2_vld <= h1_vld;
            h2_dst <= h1_dst;
            if (flush || load_use) begin
                h1_vld    <= 1'b0;
                h1_dst    <= 5'd0;
                h1_ld     <= 1'b0;
                mux_sel_A <= 2'b00;
                mux_sel_B <= 2'b00;
                imm_sel   <= 1'b0;
                // A kill abandons any pending load-use wait; a stall leaves the load one slot older
                state     <= flush ? RUN : LDSTALL;
            end else begin
                h1_vld    <= writes;
                h1_dst    <= dst;
                h1_ld     <= is_load;
                mux_sel_A <= fwd_a;
                mux_sel_B <= fwd_b;
                imm_sel   <= immf;
                state     <= RUN;
            end
        end
    end

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Purpose: scoreboard bench for hazard_fwd_ctrl against a slot-distance reference model.
// Latency: expected record pushed when inputs are driven; monitor pops and compares mid-cycle.
// Backpressure: the driver re-presents a stalled instruction until the model says it issued.
module tb_hazard_fwd_ctrl;

    localparam logic [4:0] OP_NOP  = 5'b00000;
    localparam logic [4:0] OP_LD   = 5'b10000;
    localparam logic [4:0] OP_ST   = 5'b11111;
    localparam logic [4:0] OP_ADD  = 5'b00001;
    localparam logic [4:0] OP_SUB  = 5'b00010;
    localparam logic [4:0] OP_ADDI = 5'b10001;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [23:0] ins = 24'd0;
    logic        flush = 1'b0;
    logic [1:0]  mux_sel_A;
    logic [1:0]  mux_sel_B;
    logic        imm_sel;
    logic [4:0]  RW_dm;
    logic        stall;

    always #5 clk = ~clk;

    hazard_fwd_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ins       (ins),
        .flush     (flush),
        .mux_sel_A (mux_sel_A),
        .mux_sel_B (mux_sel_B),
        .imm_sel   (imm_sel),
        .RW_dm     (RW_dm),
        .stall     (stall)
    );

    typedef struct {
        logic       v;
        logic [4:0] dst;
        logic       ld;
    } slot_t;

    typedef struct {
        logic       st;
        logic [1:0] sa;
        logic [1:0] sb;
        logic       imm;
        logic [4:0] rw;
    } exp_t;

    exp_t  exp_q[$];
    slot_t hist[$];          // pipeline slots after ID, youngest first, always 3 long
    logic  m_waiting;        // model: a load-use stall was just taken
    logic [1:0] m_sa, m_sb;
    logic  m_imm;
    logic  last_stall;
    int    n_cmp = 0;
    int    n_bad = 0;

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
        end
    endtask

    function automatic logic [23:0] mk(input logic [4:0] op, input logic [4:0] d,
                                       input logic [4:0] a, input logic [4:0] b);
        return {op, d, a, b, 4'b0000};
    endfunction

    task automatic reset_model();
        slot_t bub;
        bub = '{1'b0, 5'd0, 1'b0};
        hist.delete();
        repeat (3) hist.push_back(bub);
        m_waiting  = 1'b0;
        m_sa       = 2'b00;
        m_sb       = 2'b00;
        m_imm      = 1'b0;
        last_stall = 1'b0;
    endtask

    // Distance (1..3) to the youngest slot producing src, 0 when the bank must be read
    function automatic logic [1:0] src_dist(input logic used, input logic [4:0] src);
        if (!used || src == 5'd0) return 2'd0;
        for (int k = 0; k < 3; k++)
            if (hist[k].v && hist[k].dst == src) return 2'(k + 1);
        return 2'd0;
    endfunction

    // Drive one ID cycle, record what the DUT must show during it, then advance the model over the edge
    task automatic step(input logic [23:0] i, input logic f);
        logic [4:0] op, d, a, b;
        logic       wr, ua, ub, im, haz, st;
        logic [1:0] na, nb;
        exp_t       e;
        slot_t      s;
        @(posedge clk);
        #1;
        ins   = i;
        flush = f;
        op = i[23:19]; d = i[18:14]; a = i[13:9]; b = i[8:4];
        wr = (op != OP_NOP) && (op != OP_ST);
        ua = (op != OP_NOP);
        ub = !op[4] || (op == OP_ST);
        im = op[4] && (op != OP_ST);
        haz = !m_waiting && hist[0].v && hist[0].ld && hist[0].dst != 5'd0 &&
              ((ua && a == hist[0].dst) || (ub && b == hist[0].dst));
        st = haz && !f;
        e.st  = st;
        e.sa  = m_sa;
        e.sb  = m_sb;
        e.imm = m_imm;
        e.rw  = hist[1].v ? hist[1].dst : 5'd0;
        exp_q.push_back(e);
        na = src_dist(ua, a);
        nb = src_dist(ub, b);
        void'(hist.pop_back());
        if (f || st) begin
            s = '{1'b0, 5'd0, 1'b0};
            m_sa = 2'b00; m_sb = 2'b00; m_imm = 1'b0;
        end else begin
            s = '{wr, d, (op == OP_LD)};
            m_sa = na; m_sb = nb; m_imm = im;
        end
        hist.push_front(s);
        m_waiting  = st;
        last_stall = st;
    endtask

    // Present an instruction until it leaves ID (a stalled instruction is held upstream)
    task automatic issue(input logic [23:0] i, input logic f);
        step(i, f);
        while (last_stall) step(i, 1'b0);
    endtask

    function automatic logic [23:0] rnd_ins();
        logic [4:0] op;
        int r;
        r = $urandom_range(0, 9);
        case (r)
            0:       op = OP_NOP;
            1, 2:    op = OP_LD;
            3:       op = OP_ST;
            4, 5, 6: op = {1'b0, 4'($urandom)};
            default: op = {1'b1, 4'($urandom)};
        endcase
        return {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                5'($urandom_range(0, 7)), 4'($urandom)};
    endfunction

    // Monitor: the DUT presents a full output set every cycle; compare mid-cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("stall",     {7'd0, stall},     {7'd0, e.st});
                check("mux_sel_A", {6'd0, mux_sel_A}, {6'd0, e.sa});
                check("mux_sel_B", {6'd0, mux_sel_B}, {6'd0, e.sb});
                check("imm_sel",   {7'd0, imm_sel},   {7'd0, e.imm});
                check("RW_dm",     {3'd0, RW_dm},     {3'd0, e.rw});
            end
        end
    end

    initial begin
        logic [23:0] cur;
        logic        f;
        reset_model();
        // Reset hold: a hazard-shaped input and clock edges must not disturb the reset values
        ins = mk(OP_LD, 5'd6, 5'd1, 5'd0);
        repeat (2) @(posedge clk);
        #2;
        check("rst_sel_A", {6'd0, mux_sel_A}, 8'd0);
        check("rst_sel_B", {6'd0, mux_sel_B}, 8'd0);
        check("rst_imm",   {7'd0, imm_sel},   8'd0);
        check("rst_RW_dm", {3'd0, RW_dm},     8'd0);
        check("rst_stall", {7'd0, stall},     8'd0);
        ins = 24'd0;
        rst_n = 1'b1;

        // EX forwarding on both sources
        issue(mk(OP_ADD, 5'd3, 5'd1, 5'd2), 1'b0);
        issue(mk(OP_ADD, 5'd4, 5'd3, 5'd3), 1'b0);
        issue(24'd0, 1'b0);
        // WB forwarding on B only, RW_dm tracks DM
        issue(mk(OP_ADD, 5'd3, 5'd1, 5'd2), 1'b0);
        issue(24'd0, 1'b0);
        issue(24'd0, 1'b0);
        issue(mk(OP_SUB, 5'd5, 5'd1, 5'd3), 1'b0);
        issue(24'd0, 1'b0);
        // Load-use: one stall then DM forward
        issue(mk(OP_LD, 5'd6, 5'd2, 5'd0), 1'b0);
        issue(mk(OP_ADD, 5'd7, 5'd6, 5'd1), 1'b0);
        issue(24'd0, 1'b0);
        // Load-use killed by flush; the killed ADD must never be forwarded
        issue(mk(OP_LD, 5'd6, 5'd2, 5'd0), 1'b0);
        issue(mk(OP_ADD, 5'd7, 5'd6, 5'd1), 1'b1);
        issue(mk(OP_SUB, 5'd8, 5'd7, 5'd7), 1'b0);
        issue(24'd0, 1'b0);
        // r0 never forwarded; immediate form
        issue(mk(OP_ADD, 5'd0, 5'd1, 5'd2), 1'b0);
        issue(mk(OP_ADD, 5'd4, 5'd0, 5'd0), 1'b0);
        issue(mk(OP_ADDI, 5'd5, 5'd1, 5'd4), 1'b0);
        issue(24'd0, 1'b0);
        // Chained loads
        issue(mk(OP_LD, 5'd2, 5'd1, 5'd0), 1'b0);
        issue(mk(OP_LD, 5'd3, 5'd2, 5'd0), 1'b0);
        issue(mk(OP_ADD, 5'd4, 5'd3, 5'd2), 1'b0);
        issue(mk(OP_ST, 5'd0, 5'd4, 5'd3), 1'b0);
        issue(24'd0, 1'b0);

        // Asynchronous reset while in the stall-recovery state
        step(mk(OP_LD, 5'd6, 5'd2, 5'd0), 1'b0);
        step(mk(OP_ADD, 5'd7, 5'd6, 5'd1), 1'b0);
        step(mk(OP_ADD, 5'd7, 5'd6, 5'd1), 1'b0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        ins   = 24'd0;
        flush = 1'b0;
        #1;
        check("arst_sel_A", {6'd0, mux_sel_A}, 8'd0);
        check("arst_sel_B", {6'd0, mux_sel_B}, 8'd0);
        check("arst_imm",   {7'd0, imm_sel},   8'd0);
        check("arst_RW_dm", {3'd0, RW_dm},     8'd0);
        check("arst_stall", {7'd0, stall},     8'd0);
        reset_model();
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        issue(mk(OP_ADD, 5'd7, 5'd6, 5'd1), 1'b0);
        issue(24'd0, 1'b0);
        issue(mk(OP_ADD, 5'd8, 5'd7, 5'd7), 1'b0);
        issue(24'd0, 1'b0);
        issue(24'd0, 1'b0);

        // Randomized traffic: small register range for frequent dependencies, occasional kills
        cur = rnd_ins();
        for (int n = 0; n < 4000; n++) begin
            f = ($urandom_range(0, 9) == 0);
            step(cur, f);
            if (!last_stall) cur = rnd_ins();
        end
        issue(24'd0, 1'b0);

        repeat (3) @(negedge clk);
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d records left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
